frame_stream_source: RTL and testbench

FRAME_STREAM_SOURCE -- requirements
Module: frame_stream_source

---
 rtl/frame_stream_source.sv | 148 ++++++++++++++
 tb/tb_frame_stream_source.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/frame_stream_source.sv
// Frame streamer: walks a frame buffer in linear address order and emits
// each pixel as an Avalon-ST packet beat (one packet per frame). Reads are
// credit-limited so the 2-entry output FIFO can never overflow, while still
// sustaining one beat per cycle when the sink is always ready.
module frame_stream_source #(
  parameter int WIDTH  = 320,
  parameter int HEIGHT = 240,
  parameter int ADDR_W = 17
) (
  input  logic              clk_clk,
  input  logic              reset_reset_n,
  input  logic              enable,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [11:0]       rd_data,
  output logic              src_valid,
  input  logic              src_ready,
  output logic [11:0]       src_data,
  output logic              src_startofpacket,
  output logic              src_endofpacket,
  output logic              busy,
  output logic              frame_done
);

  localparam int unsigned       NPIX      = WIDTH * HEIGHT;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NPIX - 1);

  typedef enum logic [1:0] {IDLE, STREAM, FLUSH} state_t;

  // Packet framing flags travelling with a read.
  typedef struct packed {
    logic sop;
    logic eop;
  } tag_t;

  // One FIFO entry.
  typedef struct packed {
    logic [11:0] data;
    logic        sop;
    logic        eop;
  } beat_t;

  state_t      state_q, state_d;
  logic        vld_pipe_q;   // a read issued last cycle; rd_data valid now
  tag_t        tag_q;        // framing flags of that read
  beat_t       fifo_mem [2];
  logic        wr_ptr, rd_ptr;
  logic [1:0]  fifo_cnt;
  logic        push, pop;
  logic [2:0]  credits_used;
  beat_t       head;

  assign push         = vld_pipe_q;
  assign src_valid    = (fifo_cnt != 2'd0);
  assign pop          = src_valid & src_ready;
  assign credits_used = {1'b0, fifo_cnt} + {2'b00, vld_pipe_q};
  assign busy         = (state_q != IDLE);

  // State register.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) state_q <= IDLE;
    else                state_q <= state_d;
  end

  // Next state, read strobe and completion pulse. A beat popped this cycle
  // frees its slot at the same edge the new read is launched, so it is
  // credited back immediately; that is what allows full throughput.
  always_comb begin
    state_d    = state_q;
    rd_en      = 1'b0;
    frame_done = 1'b0;
    case (state_q)
      IDLE: begin
        if (enable) state_d = STREAM;
      end
      STREAM: begin
        if (credits_used < (3'd2 + {2'b00, pop})) rd_en = 1'b1;
        if (rd_en && (rd_addr == LAST_ADDR)) state_d = FLUSH;
      end
      FLUSH: begin
        if ((fifo_cnt == 2'd0) && !vld_pipe_q) begin
          frame_done = 1'b1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Read address: parked at 0 in IDLE so every frame starts at pixel 0.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n)        rd_addr <= '0;
    else if (state_q == IDLE)  rd_addr <= '0;
    else if (rd_en)            rd_addr <= rd_addr + 1'b1;
  end

  // Track the single in-flight read and its framing flags.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      vld_pipe_q <= 1'b0;
      tag_q      <= '0;
    end else begin
      vld_pipe_q <= rd_en;
      if (rd_en) begin
        tag_q.sop <= (rd_addr == '0);
        tag_q.eop <= (rd_addr == LAST_ADDR);
      end
    end
  end

  // FIFO storage and pointers; returning read data is written unconditionally
  // because the credit rule guarantees a free slot.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      fifo_mem[0] <= '0;
      fifo_mem[1] <= '0;
      wr_ptr      <= 1'b0;
      rd_ptr      <= 1'b0;
    end else begin
      if (push) begin
        fifo_mem[wr_ptr] <= '{data: rd_data, sop: tag_q.sop, eop: tag_q.eop};
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
    end
  end

  // Occupancy; simultaneous push and pop leaves it unchanged.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) fifo_cnt <= 2'd0;
    else begin
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
        2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  // Source outputs come straight from the FIFO head, zeroed when empty.
  always_comb begin
    head              = fifo_mem[rd_ptr];
    src_data          = src_valid ? head.data : 12'h000;
    src_startofpacket = src_valid & head.sop;
    src_endofpacket   = src_valid & head.eop;
  end

endmodule

// File: tb/tb_frame_stream_source.sv
// Directed bench for frame_stream_source on a 4x2 frame with a one-cycle
// RAM model returning addr+0x100.
module tb_frame_stream_source;

  localparam int W  = 4;
  localparam int H  = 2;
  localparam int AW = 3;

  logic          clk_clk = 1'b0;
  logic          reset_reset_n = 1'b0;
  logic          enable = 1'b0;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [11:0]   rd_data = 12'h000;
  logic          src_valid;
  logic          src_ready = 1'b0;
  logic [11:0]   src_data;
  logic          src_startofpacket;
  logic          src_endofpacket;
  logic          busy;
  logic          frame_done;

  int total = 0;
  int bad   = 0;

  frame_stream_source #(.WIDTH(W), .HEIGHT(H), .ADDR_W(AW)) dut (
    .clk_clk(clk_clk), .reset_reset_n(reset_reset_n), .enable(enable),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .src_valid(src_valid), .src_ready(src_ready), .src_data(src_data),
    .src_startofpacket(src_startofpacket), .src_endofpacket(src_endofpacket),
    .busy(busy), .frame_done(frame_done)
  );

  always #5 clk_clk = ~clk_clk;

  // Frame-buffer model: one cycle read latency.
  always @(posedge clk_clk) if (rd_en) rd_data <= 12'h100 + {9'b0, rd_addr};

  typedef struct {
    logic          en, rdy;
    logic          rd_en;
    logic [AW-1:0] addr;
    logic          valid;
    logic [11:0]   data;
    logic          sop, eop, busy, fd;
  } vec_t;

  vec_t vecs[16];

  function automatic vec_t mk(input logic en, input logic rdy, input logic re,
                              input logic [AW-1:0] a, input logic v, input logic [11:0] d,
                              input logic s, input logic e, input logic b, input logic f);
    vec_t t;
    t.en = en; t.rdy = rdy; t.rd_en = re; t.addr = a; t.valid = v;
    t.data = d; t.sop = s; t.eop = e; t.busy = b; t.fd = f;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] obs();
    return 32'({rd_en, rd_addr, src_valid, src_data, src_startofpacket,
                src_endofpacket, busy, frame_done});
  endfunction

  task automatic do_reset();
    reset_reset_n = 1'b0;
    enable        = 1'b0;
    src_ready     = 1'b0;
    repeat (2) @(posedge clk_clk);
    @(negedge clk_clk);
    reset_reset_n = 1'b1;
  endtask

  // Run one frame with a repeating ready pattern, dropping enable once
  // drop_after beats have been delivered. Checks order, framing, stall
  // stability and the two-credit limit on every cycle.
  task automatic stream_frame(input logic [3:0] pat, input int drop_after, input string nm);
    int          xfer = 0, issued = 0, cyc = 0, used;
    logic        stall = 1'b0, done = 1'b0, p;
    logic [11:0] pd = 12'h000;
    logic        ps = 1'b0, pe = 1'b0;
    enable = 1'b1;
    while (!done && cyc < 300) begin
      @(negedge clk_clk);
      src_ready = pat[cyc[1:0]];
      if (xfer >= drop_after) enable = 1'b0;
      #1;
      p = src_valid & src_ready;
      if (stall)
        chk({nm, " hold"}, 32'({src_valid, src_data, src_startofpacket, src_endofpacket}),
            32'({1'b1, pd, ps, pe}));
      if (rd_en) begin
        used = issued - xfer - (p ? 1 : 0);
        chk({nm, " credit"}, 32'(used < 2), 32'd1);
        issued++;
      end
      if (p) begin
        chk({nm, " beat"}, 32'({src_data, src_startofpacket, src_endofpacket}),
            32'({12'h100 + 12'(xfer), xfer == 0, xfer == W*H-1}));
        xfer++;
      end
      stall = src_valid & ~src_ready;
      pd = src_data; ps = src_startofpacket; pe = src_endofpacket;
      if (frame_done) done = 1'b1;
      cyc++;
    end
    chk({nm, " frame_done seen"}, 32'(done), 32'd1);
    chk({nm, " beats"}, 32'(xfer), 32'(W*H));
    chk({nm, " reads"}, 32'(issued), 32'(W*H));
    repeat (2) begin
      @(negedge clk_clk); #1;
      chk({nm, " idle after"}, 32'({busy, rd_en, src_valid}), 32'd0);
    end
  endtask

  initial begin
    int          n, xfer;
    logic [AW-1:0] got[2];

    // Full-rate frame followed by the start of a back-to-back frame.
    vecs[0]  = mk(1'b1,1'b1, 1'b0,3'd0, 1'b0,12'h000, 1'b0,1'b0, 1'b0,1'b0);
    vecs[1]  = mk(1'b1,1'b1, 1'b1,3'd0, 1'b0,12'h000, 1'b0,1'b0, 1'b1,1'b0);
    vecs[2]  = mk(1'b1,1'b1, 1'b1,3'd1, 1'b0,12'h000, 1'b0,1'b0, 1'b1,1'b0);
    vecs[3]  = mk(1'b1,1'b1, 1'b1,3'd2, 1'b1,12'h100, 1'b1,1'b0, 1'b1,1'b0);
    vecs[4]  = mk(1'b1,1'b1, 1'b1,3'd3, 1'b1,12'h101, 1'b0,1'b0, 1'b1,1'b0);
    vecs[5]  = mk(1'b1,1'b1, 1'b1,3'd4, 1'b1,12'h102, 1'b0,1'b0, 1'b1,1'b0);
    vecs[6]  = mk(1'b1,1'b1, 1'b1,3'd5, 1'b1,12'h103, 1'b0,1'b0, 1'b1,1'b0);
    vecs[7]  = mk(1'b1,1'b1, 1'b1,3'd6, 1'b1,12'h104, 1'b0,1'b0, 1'b1,1'b0);
    vecs[8]  = mk(1'b1,1'b1, 1'b1,3'd7, 1'b1,12'h105, 1'b0,1'b0, 1'b1,1'b0);
    vecs[9]  = mk(1'b1,1'b1, 1'b0,3'd0, 1'b1,12'h106, 1'b0,1'b0, 1'b1,1'b0);
    vecs[10] = mk(1'b1,1'b1, 1'b0,3'd0, 1'b1,12'h107, 1'b0,1'b1, 1'b1,1'b0);
    vecs[11] = mk(1'b1,1'b1, 1'b0,3'd0, 1'b0,12'h000, 1'b0,1'b0, 1'b1,1'b1);
    vecs[12] = mk(1'b1,1'b1, 1'b0,3'd0, 1'b0,12'h000, 1'b0,1'b0, 1'b0,1'b0);
    vecs[13] = mk(1'b1,1'b1, 1'b1,3'd0, 1'b0,12'h000, 1'b0,1'b0, 1'b1,1'b0);
    vecs[14] = mk(1'b1,1'b1, 1'b1,3'd1, 1'b0,12'h000, 1'b0,1'b0, 1'b1,1'b0);
    vecs[15] = mk(1'b1,1'b1, 1'b1,3'd2, 1'b1,12'h100, 1'b1,1'b0, 1'b1,1'b0);

    do_reset();
    #1;
    chk("reset state", obs(), 32'd0);

    for (int i = 0; i < 16; i++) begin
      @(negedge clk_clk);
      enable    = vecs[i].en;
      src_ready = vecs[i].rdy;
      #1;
      chk($sformatf("vec%0d", i), obs(),
          32'({vecs[i].rd_en, vecs[i].addr, vecs[i].valid, vecs[i].data,
               vecs[i].sop, vecs[i].eop, vecs[i].busy, vecs[i].fd}));
    end

    // Ready toggling 1,0,0,1.
    do_reset();
    stream_frame(4'b1001, 1, "toggle");

    // Enable dropped after the third beat.
    do_reset();
    stream_frame(4'b1111, 3, "drop_en");

    // Reset after the fifth beat, then a clean restart.
    do_reset();
    enable = 1'b1; src_ready = 1'b1;
    xfer = 0; n = 0;
    while (xfer < 5 && n < 100) begin
      @(negedge clk_clk); #1;
      if (src_valid && src_ready) xfer++;
      n++;
    end
    chk("5 beats before reset", 32'(xfer), 32'd5);
    @(negedge clk_clk);
    reset_reset_n = 1'b0;
    #1;
    chk("async reset outputs", obs(), 32'd0);
    repeat (2) @(posedge clk_clk);
    @(negedge clk_clk);
    enable = 1'b0;
    reset_reset_n = 1'b1;
    stream_frame(4'b1111, 1, "restart");

    // Sink stalled from the start: only two reads may be outstanding.
    do_reset();
    enable = 1'b1; src_ready = 1'b0;
    n = 0; got[0] = '1; got[1] = '1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk_clk); #1;
      if (rd_en) begin
        if (n < 2) got[n] = rd_addr;
        n++;
      end
    end
    chk("stall read count", 32'(n), 32'd2);
    chk("stall addr0", 32'(got[0]), 32'd0);
    chk("stall addr1", 32'(got[1]), 32'd1);
    chk("stall head", 32'({src_valid, src_data, src_startofpacket, src_endofpacket}),
        32'({1'b1, 12'h100, 1'b1, 1'b0}));
    do_reset();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
